mio_bus: RTL and testbench
==========================

# mio_bus

Memory/IO bus controller sitting directly downstream of the single-cycle CPU datapath: consumes its address, store data and 2-bit store-width code, and returns the load word on the CPU data-in path. Decodes the address into data RAM or memory-mapped peripherals, generates RAM byte-lane write enables, and contains the GPIO output register and the programmable countdown counter (counter0) whose interrupt feeds the CPU `INT` input.

## Interface
Parameters:
- `RAM_AW`, 10, RAM word-address width (1024 words, byte range 0x0000_0000–0x0000_0FFF)
- `GPIO_W`, 16, GPIO in/out width

Ports:
- `clk`  in  1  CPU clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cpu_addr`  in  32  byte address from CPU ALU result
- `cpu_wdata`  in  32  store data from CPU
- `mem_w`  in  2  store code: 00 none, 01 word, 10 halfword, 11 byte
- `cpu_rdata`  out  32  load data to CPU `Data_in`
- `ram_addr`  out  RAM_AW  `cpu_addr[RAM_AW+1:2]`
- `ram_wdata`  out  32  lane-replicated store data
- `ram_we`  out  4  byte-lane write enables, bit n = byte lane n
- `ram_rdata`  in  32  asynchronous-read RAM data
- `gpio_in`  in  GPIO_W  switch inputs
- `gpio_out`  out  GPIO_W  LED register
- `counter0_out`  out  1  counter0 interrupt request

## Operation
- Region decode: RAM when `cpu_addr[31:12]==0`; PERIPH when `cpu_addr[31:4]==28'hF000_000`; else UNMAPPED.
- RAM stores, little-endian: word -> `ram_we=4'b1111`, `ram_wdata=cpu_wdata`; half -> lanes {1,0} if `addr[1]==0` else {3,2}, `addr[0]` ignored, `ram_wdata={2{wdata[15:0]}}`; byte -> lane `addr[1:0]`, `ram_wdata={4{wdata[7:0]}}`. `ram_we=0` when `mem_w==00` or region≠RAM.
- Peripheral registers (word stores only; sub-word stores ignored):
  - 0xF000_0000 GPIO: write loads `gpio_out<=wdata[GPIO_W-1:0]`; read `{gpio_in, gpio_out}`.
  - 0xF000_0004 RELOAD: write stores reload value and also loads COUNT; read returns reload.
  - 0xF000_0008 CTRL: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - 0xF000_000C COUNT/STATUS: read `{COUNT[30:0], IRQ}`; write with `wdata[0]=1` clears IRQ.
- Counter FSM, IDLE (EN=0) / RUN (EN=1):
  - RUN, COUNT≠0: COUNT decrements by 1 per cycle.
  - RUN, COUNT==0: IRQ<=1; AUTO=1 -> COUNT<=RELOAD, stay RUN; AUTO=0 -> EN<=0, go IDLE.
  - IDLE: COUNT holds.
- `counter0_out = IRQ & IE`, combinational from registers.
- Reads: `cpu_rdata` combinational mux: RAM -> `ram_rdata`; PERIPH -> selected register; UNMAPPED -> 0. Loads always return the full word; byte/half extraction is the CPU's job.

## Timing
- Reset (async assert): `gpio_out`, RELOAD, CTRL, COUNT, IRQ all 0; `counter0_out=0`. No RAM write may occur while `reset` is high.
- Read latency 0 cycles (combinational), required by the single-cycle CPU.
- Register writes take effect at the clock edge ending the store cycle; a read in the following cycle sees the new value.
- Simultaneous events, same edge:
  - RELOAD write in RUN: load wins, no decrement that cycle.
  - CTRL write and expiry: the CTRL write value wins for EN; IRQ still sets.
  - STATUS clear and expiry: set wins, IRQ=1.
- Expiry timing: COUNT=N with EN=1 raises IRQ at the edge N+1 cycles later.
- RELOAD=0 with AUTO=1: IRQ reasserts every cycle.

## Structure
- `mio_pkg`: region base constants, peripheral offsets, `mem_w` encodings (MW_NONE/WORD/HALF/BYTE), CTRL bit indices.
- Sub-module `mio_counter`: RELOAD/CTRL/COUNT/IRQ registers and FSM, with write strobes and write data in, register read data and irq out.
- Top level contains decode, lane logic, GPIO register and the read mux.

## Test plan
- Byte store 0xA5 at 0x0000_0013 -> `ram_we=4'b1000`, `ram_wdata=0xA5A5A5A5`, `ram_addr=4`; halfword store at 0x12 -> `ram_we=4'b1100`.
- Word store 0x0000_BEEF to 0xF000_0000 with `gpio_in=0x1234` -> `gpio_out=0xBEEF`; next-cycle load returns 0x1234BEEF; byte store to the same address leaves it unchanged.
- RELOAD=3, CTRL=0b101 -> IRQ and `counter0_out` rise 4 cycles after EN; EN clears; COUNT stays 0.
- AUTO=1, RELOAD=2 -> `counter0_out` sets on the first expiry; STATUS clear coinciding with the second expiry leaves IRQ=1.
- Assert `reset` mid-countdown between clock edges -> all registers 0 and `counter0_out=0` immediately; no RAM write while `reset` is high.
- Load from 0x8000_0000 -> `cpu_rdata=0`; store there -> `ram_we=0`, no register change.

Source files
------------

// File: rtl/mio_pkg.sv
// mio_pkg: shared constants and types for the mio_bus memory/IO controller.
// Holds the region decode constants, peripheral register offsets, store-width
// codes, CTRL bit positions and the counter0 FSM state type.
package mio_pkg;

  // Region decode: RAM when addr[31:12] matches, PERIPH when addr[31:4] matches
  localparam logic [19:0] RAM_BASE_HI    = 20'h0_0000;
  localparam logic [27:0] PERIPH_BASE_HI = 28'hF00_0000;

  typedef enum logic [1:0] {
    RGN_RAM    = 2'd0,
    RGN_PERIPH = 2'd1,
    RGN_NONE   = 2'd2
  } region_e;

  // Store-width codes from the CPU
  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_WORD = 2'b01,
    MW_HALF = 2'b10,
    MW_BYTE = 2'b11
  } mem_w_e;

  // Peripheral register select, taken from addr[3:2]
  typedef enum logic [1:0] {
    REG_GPIO   = 2'd0,
    REG_RELOAD = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_AUTO = 1;
  localparam int unsigned CTRL_IE   = 2;

  typedef enum logic {
    CNT_IDLE = 1'b0,
    CNT_RUN  = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/mio_counter.sv
// mio_counter: counter0 peripheral (RELOAD, CTRL, COUNT, IRQ) and its FSM.
// Ports:
//   clk, reset            clock, async active-high reset
//   we_reload/ctrl/status word-store strobes for each register
//   wdata                 store data
//   reload_o              RELOAD read value
//   ctrl_o                CTRL read value {.., IE, AUTO, EN}
//   status_o              STATUS read value {COUNT[30:0], IRQ}
//   irq_o                 IRQ & IE
module mio_counter
  import mio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_reload,
  input  logic        we_ctrl,
  input  logic        we_status,
  input  logic [31:0] wdata,
  output logic [31:0] reload_o,
  output logic [31:0] ctrl_o,
  output logic [31:0] status_o,
  output logic        irq_o
);

  localparam int unsigned CNT_W = 32;

  // EN is represented by the FSM state itself
  cnt_state_e         state_q, state_d;
  logic               auto_q, auto_d;
  logic               ie_q, ie_d;
  logic               irq_q, irq_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               expire_c;

  assign expire_c = (state_q == CNT_RUN) && (count_q == '0);

  // Next-state: countdown first, then register writes override it
  always_comb begin
    state_d  = state_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    irq_d    = irq_q;
    reload_d = reload_q;
    count_d  = count_q;

    if (state_q == CNT_RUN) begin
      if (!expire_c) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        irq_d = 1'b1;
        if (auto_q) count_d = reload_q;
        else        state_d = CNT_IDLE;
      end
    end

    if (we_reload) begin
      reload_d = wdata;
      count_d  = wdata;
    end

    if (we_ctrl) begin
      state_d = wdata[CTRL_EN] ? CNT_RUN : CNT_IDLE;
      auto_d  = wdata[CTRL_AUTO];
      ie_d    = wdata[CTRL_IE];
    end

    // An expiry on the same edge as a clear keeps IRQ set
    if (we_status && wdata[0] && !expire_c) irq_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CNT_IDLE;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
      reload_q <= reload_d;
      count_q  <= count_d;
    end
  end

  assign reload_o = reload_q;
  assign ctrl_o   = {29'd0, ie_q, auto_q, (state_q == CNT_RUN)};
  assign status_o = {count_q[30:0], irq_q};
  assign irq_o    = irq_q & ie_q;

endmodule

// File: rtl/mio_bus.sv
// mio_bus: memory/IO bus controller behind the single-cycle CPU datapath.
// Decodes the CPU address into RAM / peripherals / unmapped, builds RAM
// byte-lane enables and replicated store data, holds the GPIO output register
// and the counter0 peripheral, and muxes load data back to the CPU.
// Ports:
//   clk, reset              clock, async active-high reset
//   cpu_addr/wdata/mem_w    CPU address, store data, store-width code
//   cpu_rdata               load word to CPU (combinational)
//   ram_addr/wdata/we       RAM word address, store data, byte-lane enables
//   ram_rdata               asynchronous RAM read data
//   gpio_in/gpio_out        switch inputs / LED register
//   counter0_out            counter0 interrupt request
module mio_bus
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW = 10,
  parameter int unsigned GPIO_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [1:0]        mem_w,
  output logic [31:0]       cpu_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_we,
  input  logic [31:0]       ram_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              counter0_out
);

  region_e            region_c;
  mem_w_e             mw_c;
  reg_sel_e           sel_c;
  logic               periph_wr_c;
  logic [GPIO_W-1:0]  gpio_q, gpio_d;
  logic [31:0]        cnt_reload, cnt_ctrl, cnt_status;

  assign mw_c  = mem_w_e'(mem_w);
  assign sel_c = reg_sel_e'(cpu_addr[3:2]);

  // Address region decode
  always_comb begin
    region_c = RGN_NONE;
    if (cpu_addr[31:12] == RAM_BASE_HI)        region_c = RGN_RAM;
    else if (cpu_addr[31:4] == PERIPH_BASE_HI) region_c = RGN_PERIPH;
  end

  // Peripheral registers accept word stores only
  assign periph_wr_c = (region_c == RGN_PERIPH) && (mw_c == MW_WORD);

  // RAM byte-lane enables and lane-replicated store data
  always_comb begin
    ram_we    = 4'b0000;
    ram_wdata = cpu_wdata;
    case (mw_c)
      MW_WORD: ram_we = 4'b1111;
      MW_HALF: begin
        ram_we    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{cpu_wdata[15:0]}};
      end
      MW_BYTE: begin
        ram_we    = 4'b0001 << cpu_addr[1:0];
        ram_wdata = {4{cpu_wdata[7:0]}};
      end
      default: ram_we = 4'b0000;
    endcase
    if (reset || (region_c != RGN_RAM)) ram_we = 4'b0000;
  end

  assign ram_addr = cpu_addr[RAM_AW+1:2];

  // GPIO output register
  always_comb begin
    gpio_d = gpio_q;
    if (periph_wr_c && (sel_c == REG_GPIO)) gpio_d = cpu_wdata[GPIO_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gpio_q <= '0;
    else       gpio_q <= gpio_d;
  end

  assign gpio_out = gpio_q;

  mio_counter u_counter0 (
    .clk       (clk),
    .reset     (reset),
    .we_reload (periph_wr_c && (sel_c == REG_RELOAD)),
    .we_ctrl   (periph_wr_c && (sel_c == REG_CTRL)),
    .we_status (periph_wr_c && (sel_c == REG_STATUS)),
    .wdata     (cpu_wdata),
    .reload_o  (cnt_reload),
    .ctrl_o    (cnt_ctrl),
    .status_o  (cnt_status),
    .irq_o     (counter0_out)
  );

  // Zero-latency load mux
  always_comb begin
    cpu_rdata = 32'd0;
    case (region_c)
      RGN_RAM: cpu_rdata = ram_rdata;
      RGN_PERIPH: begin
        case (sel_c)
          REG_GPIO:   cpu_rdata = 32'({gpio_in, gpio_q});
          REG_RELOAD: cpu_rdata = cnt_reload;
          REG_CTRL:   cpu_rdata = cnt_ctrl;
          REG_STATUS: cpu_rdata = cnt_status;
          default:    cpu_rdata = 32'd0;
        endcase
      end
      default: cpu_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mio_bus.sv
// tb_mio_bus: self-checking bench for mio_bus with directed scenarios and
// randomized traffic compared against a behavioural model of the registers.
module tb_mio_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic [1:0]  mem_w;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [15:0] gpio_in, gpio_out;
  logic        counter0_out;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the register file
  logic [15:0] m_gpio;
  logic [31:0] m_reload, m_count;
  logic        m_en, m_auto, m_ie, m_irq;

  always #5 clk = ~clk;

  mio_bus #(.RAM_AW(10), .GPIO_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .mem_w        (mem_w),
    .cpu_rdata    (cpu_rdata),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_we       (ram_we),
    .ram_rdata    (ram_rdata),
    .gpio_in      (gpio_in),
    .gpio_out     (gpio_out),
    .counter0_out (counter0_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_gpio = '0; m_reload = '0; m_count = '0;
    m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_irq = 1'b0;
  endtask

  function automatic int store_size(input logic [1:0] mw);
    return (mw == 2'd1) ? 4 : (mw == 2'd2) ? 2 : (mw == 2'd3) ? 1 : 0;
  endfunction

  // A lane is written when its byte address falls inside the aligned store
  function automatic logic [3:0] exp_we_f(input logic [31:0] a, input logic [1:0] mw);
    logic [3:0] r;
    int sz, start;
    r  = 4'b0000;
    sz = store_size(mw);
    if (reset || sz == 0 || a[31:12] != 20'd0) return r;
    start = (int'(a[1:0]) / sz) * sz;
    for (int i = 0; i < 4; i++) if (i >= start && i < start + sz) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata_f(input logic [31:0] w, input logic [1:0] mw);
    case (store_size(mw))
      2:       return (w & 32'h0000_FFFF) * 32'h0001_0001;
      1:       return (w & 32'h0000_00FF) * 32'h0101_0101;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata_f(input logic [31:0] a);
    if (a[31:12] == 20'd0) return ram_rdata;
    if (a[31:4] != 28'hF00_0000) return 32'd0;
    case (a[3:2])
      2'd0:    return {gpio_in, m_gpio};
      2'd1:    return m_reload;
      2'd2:    return {29'd0, m_ie, m_auto, m_en};
      default: return {m_count[30:0], m_irq};
    endcase
  endfunction

  task automatic check_outputs();
    logic [3:0] ew;
    ew = exp_we_f(cpu_addr, mem_w);
    chk("ram_we", 32'(ram_we), 32'(ew));
    if (ew != 4'd0) chk("ram_wdata", ram_wdata, exp_wdata_f(cpu_wdata, mem_w));
    chk("ram_addr", 32'(ram_addr), 32'(cpu_addr[11:2]));
    chk("cpu_rdata", cpu_rdata, exp_rdata_f(cpu_addr));
    chk("gpio_out", 32'(gpio_out), 32'(m_gpio));
    chk("counter0_out", 32'(counter0_out), 32'(m_irq & m_ie));
  endtask

  // One clock edge of the model, using the inputs held during the cycle
  task automatic model_step();
    logic expired, pw;
    expired = m_en && (m_count == 32'd0);
    pw      = (cpu_addr[31:4] == 28'hF00_0000) && (mem_w == 2'd1);
    if (m_en) begin
      if (expired) begin
        m_irq = 1'b1;
        if (m_auto) m_count = m_reload;
        else        m_en = 1'b0;
      end else begin
        m_count = m_count - 32'd1;
      end
    end
    if (pw) begin
      case (cpu_addr[3:2])
        2'd0: m_gpio = cpu_wdata[15:0];
        2'd1: begin m_reload = cpu_wdata; m_count = cpu_wdata; end
        2'd2: begin m_en = cpu_wdata[0]; m_auto = cpu_wdata[1]; m_ie = cpu_wdata[2]; end
        default: if (cpu_wdata[0] && !expired) m_irq = 1'b0;
      endcase
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] w, input logic [1:0] mw);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wdata = w;
    mem_w     = mw;
    ram_rdata = $urandom();
    #1;
    check_outputs();
  endtask

  task automatic clock();
    @(posedge clk);
    model_step();
  endtask

  task automatic cycle(input logic [31:0] a, input logic [31:0] w, input logic [1:0] mw);
    drive(a, w, mw);
    clock();
  endtask

  localparam logic [31:0] A_GPIO   = 32'hF000_0000;
  localparam logic [31:0] A_RELOAD = 32'hF000_0004;
  localparam logic [31:0] A_CTRL   = 32'hF000_0008;
  localparam logic [31:0] A_STATUS = 32'hF000_000C;

  initial begin
    int rise;
    logic [31:0] a, w;

    reset = 1'b1;
    cpu_addr = '0; cpu_wdata = '0; mem_w = 2'd0; ram_rdata = '0;
    gpio_in = 16'h1234;
    model_reset();

    // Reset state, and no RAM write while reset is high
    #2;
    cpu_addr = 32'h10; mem_w = 2'd1; cpu_wdata = 32'hFFFF_FFFF;
    #1 chk("we_in_reset", 32'(ram_we), 32'd0);
    mem_w = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cpu_addr = A_GPIO + 32'(i * 4);
      #1 chk("reset_reg", cpu_rdata, (i == 0) ? 32'h1234_0000 : 32'd0);
    end
    chk("reset_irq", 32'(counter0_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Byte and halfword RAM stores
    drive(32'h0000_0013, 32'h0000_00A5, 2'd3);
    chk("byte_we", 32'(ram_we), 32'h8);
    chk("byte_wdata", ram_wdata, 32'hA5A5_A5A5);
    chk("byte_addr", 32'(ram_addr), 32'd4);
    clock();
    drive(32'h0000_0012, 32'h0000_BEEF, 2'd2);
    chk("half_we", 32'(ram_we), 32'hC);
    chk("half_wdata", ram_wdata, 32'hBEEF_BEEF);
    clock();

    // GPIO write, readback, and ignored byte store
    cycle(A_GPIO, 32'h0000_BEEF, 2'd1);
    #1 chk("gpio_out_word", 32'(gpio_out), 32'h0000_BEEF);
    drive(A_GPIO, 32'd0, 2'd0);
    chk("gpio_read", cpu_rdata, 32'h1234_BEEF);
    clock();
    cycle(A_GPIO, 32'h0000_0055, 2'd3);
    drive(A_GPIO, 32'd0, 2'd0);
    chk("gpio_byte_ignored", cpu_rdata, 32'h1234_BEEF);
    clock();

    // One-shot countdown: RELOAD=3, EN|IE
    cycle(A_RELOAD, 32'd3, 2'd1);
    cycle(A_CTRL, 32'd5, 2'd1);
    rise = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(A_STATUS, 32'd0, 2'd0);
      #1 if (counter0_out && rise == 0) rise = i;
    end
    chk("oneshot_rise", 32'(rise), 32'd4);
    drive(A_CTRL, 32'd0, 2'd0);
    chk("oneshot_en_clr", cpu_rdata, 32'h4);
    clock();
    drive(A_STATUS, 32'd0, 2'd0);
    chk("oneshot_status", cpu_rdata, 32'h1);
    clock();

    // Auto reload: clear on second expiry keeps IRQ set
    cycle(A_STATUS, 32'd1, 2'd1);
    cycle(A_RELOAD, 32'd2, 2'd1);
    cycle(A_CTRL, 32'd7, 2'd1);
    for (int i = 0; i < 3; i++) cycle(A_STATUS, 32'd0, 2'd0);
    #1 chk("auto_first", 32'(counter0_out), 32'd1);
    cycle(A_STATUS, 32'd1, 2'd1);
    #1 chk("auto_clear", 32'(counter0_out), 32'd0);
    cycle(A_STATUS, 32'd0, 2'd0);
    cycle(A_STATUS, 32'd1, 2'd1);
    #1 chk("clear_vs_set", 32'(counter0_out), 32'd1);
    cycle(A_STATUS, 32'd0, 2'd0);
    cycle(A_STATUS, 32'd0, 2'd0);

    // Async reset mid-countdown with a RAM store pending
    @(negedge clk);
    cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF; mem_w = 2'd1;
    #2 reset = 1'b1;
    model_reset();
    #1 chk("rst_irq_now", 32'(counter0_out), 32'd0);
    chk("rst_we_now", 32'(ram_we), 32'd0);
    chk("rst_gpio_now", 32'(gpio_out), 32'd0);
    mem_w = 2'd0;
    for (int i = 1; i < 4; i++) begin
      cpu_addr = A_GPIO + 32'(i * 4);
      #1 chk("rst_reg_now", cpu_rdata, 32'd0);
    end
    cpu_addr = 32'h20; mem_w = 2'd1;
    @(posedge clk);
    #1 chk("rst_we_edge", 32'(ram_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_w = 2'd0;

    // Unmapped access
    drive(32'h8000_0000, 32'd0, 2'd0);
    chk("unmapped_read", cpu_rdata, 32'd0);
    clock();
    drive(32'h8000_0000, 32'hFFFF_FFFF, 2'd1);
    chk("unmapped_we", 32'(ram_we), 32'd0);
    clock();
    for (int i = 0; i < 4; i++) cycle(A_GPIO + 32'(i * 4), 32'd0, 2'd0);

    // RELOAD=0 with AUTO: IRQ every cycle
    cycle(A_RELOAD, 32'd0, 2'd1);
    cycle(A_CTRL, 32'd7, 2'd1);
    cycle(A_STATUS, 32'd0, 2'd0);
    cycle(A_STATUS, 32'd1, 2'd1);
    #1 chk("reload0_irq", 32'(counter0_out), 32'd1);
    cycle(A_CTRL, 32'd0, 2'd1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = 32'($urandom_range(0, 32'h0FFF));
        2, 3:    a = A_GPIO | 32'($urandom_range(0, 3) << 2);
        default: a = $urandom() | 32'h8000_0000;
      endcase
      w = (a == A_RELOAD) ? 32'($urandom_range(0, 6)) : $urandom();
      if ($urandom_range(0, 15) == 0) gpio_in = 16'($urandom());
      cycle(a, w, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
